// File: rtl/acknack_out_buffer_param.sv
// Go-back-N ACK/NACK retransmission output buffer with generic depth and width.
// Each flit is held until it is acknowledged. A NACK replays from the oldest unacknowledged flit.
module acknack_out_buffer_param #(
    parameter int FLITWIDTH = 32,
    parameter int DEPTH     = 8,
    parameter int LOGDEPTH  = 3,
    parameter int CNTWIDTH  = 16,
    parameter int SIMDELAY  = 2000
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [FLITWIDTH-1:0] FLIT_out,
    output logic                 VALID_out,
    output logic                 FWDAUX1_out,
    input  logic                 BWDAUX1_in,
    input  logic                 BWDAUX2_in,
    input  logic                 BWDAUX3_in,
    input  logic                 write,
    input  logic [FLITWIDTH-1:0] data_in,
    output logic                 full,
    output logic                 almost_full,
    output logic [LOGDEPTH:0]    occupancy,
    output logic [CNTWIDTH-1:0]  replay_count,
    output logic                 overflow_err,
    output logic                 spurious_ack_err
);

    localparam logic [LOGDEPTH-1:0] PTR_ONE   = LOGDEPTH'(1);
    localparam logic [LOGDEPTH:0]   CNT_FULL  = (LOGDEPTH+1)'(DEPTH);
    localparam logic [LOGDEPTH:0]   CNT_ALMST = (LOGDEPTH+1)'(DEPTH-1);

    // The transport delay is a simulation-only modelling aid and is not applied in this RTL.
    if (SIMDELAY < 0) begin : gSimDelayCheck
    end

    logic unusedAux;
    assign unusedAux = &{1'b0, BWDAUX3_in};

    logic [FLITWIDTH-1:0] mem_q [DEPTH];
    logic [LOGDEPTH-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d, ackPtr_q, ackPtr_d;
    logic [LOGDEPTH-1:0]  discard_q, discard_d;
    logic [LOGDEPTH:0]    unsent_q, unsent_d, occ_q, occ_d;
    logic [CNTWIDTH-1:0]  count_q, count_d;
    logic                 replay_q, replay_d, ovf_q, ovf_d, spur_q, spur_d;
    logic                 push, respTaken, nackTaken, ackTaken, ackRetire, sendAdv;
    logic [LOGDEPTH:0]    pushExt, retireExt, sendExt;

    assign full             = (occ_q == CNT_FULL);
    assign almost_full      = (occ_q >= CNT_ALMST);
    assign occupancy        = occ_q;
    assign replay_count     = count_q;
    assign overflow_err     = ovf_q;
    assign spurious_ack_err = spur_q;
    assign FLIT_out         = mem_q[rdPtr_q];
    assign VALID_out        = (unsent_q != '0) || replay_q;
    assign FWDAUX1_out      = replay_q;

    always_comb begin
        push      = write && !full;
        respTaken = BWDAUX2_in && (discard_q == '0);
        nackTaken = respTaken && !BWDAUX1_in;
        ackTaken  = respTaken && BWDAUX1_in;
        ackRetire = ackTaken && (occ_q != '0);
        sendAdv   = (unsent_q != '0) && !nackTaken;
        pushExt   = {{LOGDEPTH{1'b0}}, push};
        retireExt = {{LOGDEPTH{1'b0}}, ackRetire};
        sendExt   = {{LOGDEPTH{1'b0}}, sendAdv};

        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        ackPtr_d  = ackPtr_q;
        discard_d = discard_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        spur_d    = spur_q;
        replay_d  = nackTaken;
        occ_d     = occ_q + pushExt - retireExt;
        unsent_d  = unsent_q + pushExt - sendExt;

        if (push)
            wrPtr_d = wrPtr_q + PTR_ONE;
        if (write && full)
            ovf_d = 1'b1;
        if (BWDAUX2_in && (discard_q != '0))
            discard_d = discard_q - PTR_ONE;
        if (ackRetire)
            ackPtr_d = ackPtr_q + PTR_ONE;
        if (ackTaken && (occ_q == '0))
            spur_d = 1'b1;

        // Rewind: everything still held becomes unsent again, and the in-flight flits
        // beyond the NACKed one will each draw a NACK that must be swallowed.
        if (nackTaken) begin
            rdPtr_d   = ackPtr_q;
            unsent_d  = occ_q + pushExt;
            discard_d = rdPtr_q - ackPtr_q - PTR_ONE;
            if (count_q != '1)
                count_d = count_q + CNTWIDTH'(1);
        end else if (sendAdv) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            ackPtr_q  <= '0;
            discard_q <= '0;
            unsent_q  <= '0;
            occ_q     <= '0;
            count_q   <= '0;
            replay_q  <= 1'b0;
            ovf_q     <= 1'b0;
            spur_q    <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            ackPtr_q  <= ackPtr_d;
            discard_q <= discard_d;
            unsent_q  <= unsent_d;
            occ_q     <= occ_d;
            count_q   <= count_d;
            replay_q  <= replay_d;
            ovf_q     <= ovf_d;
            spur_q    <= spur_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wrPtr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_acknack_out_buffer_param.sv
// Randomised bench for acknack_out_buffer_param, checked every cycle against a queue-based
// model of held flits plus directed scenarios with hand-computed expectations.
module tb_acknack_out_buffer_param;

    localparam int FW     = 16;
    localparam int DEPTH  = 4;
    localparam int LOGD   = 2;
    localparam int CW     = 2;
    localparam int MAXCNT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [FW-1:0] FLIT_out;
    logic          VALID_out, FWDAUX1_out;
    logic          respAck = 1'b0, respValid = 1'b0, aux3 = 1'b0;
    logic          writeIn = 1'b0;
    logic [FW-1:0] dataIn = '0;
    logic          full, almost_full;
    logic [LOGD:0] occupancy;
    logic [CW-1:0] replay_count;
    logic          overflow_err, spurious_ack_err;

    int checks = 0;
    int errors = 0;
    bit cmpEn  = 1'b0;

    acknack_out_buffer_param #(
        .FLITWIDTH(FW), .DEPTH(DEPTH), .LOGDEPTH(LOGD), .CNTWIDTH(CW), .SIMDELAY(0)
    ) dut (
        .clk(clk), .rst(rst),
        .FLIT_out(FLIT_out), .VALID_out(VALID_out), .FWDAUX1_out(FWDAUX1_out),
        .BWDAUX1_in(respAck), .BWDAUX2_in(respValid), .BWDAUX3_in(aux3),
        .write(writeIn), .data_in(dataIn),
        .full(full), .almost_full(almost_full), .occupancy(occupancy),
        .replay_count(replay_count), .overflow_err(overflow_err),
        .spurious_ack_err(spurious_ack_err)
    );

    always #5 clk = ~clk;

    // Model: queue of unacknowledged flits and how many of them have been sent since the last rewind.
    logic [FW-1:0] held[$];
    int  sentIdx  = 0;
    int  mDiscard = 0;
    int  mCount   = 0;
    bit  mReplay  = 1'b0, mOvf = 1'b0, mSpur = 1'b0;
    bit  fullPre, accepted, isNack, isAck, doSend, doPush;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            held.delete();
            sentIdx = 0; mDiscard = 0; mCount = 0;
            mReplay = 1'b0; mOvf = 1'b0; mSpur = 1'b0;
        end else begin
            fullPre  = (held.size() == DEPTH);
            doPush   = writeIn && !fullPre;
            if (writeIn && fullPre) mOvf = 1'b1;
            accepted = respValid && (mDiscard == 0);
            if (respValid && mDiscard > 0) mDiscard--;
            isNack   = accepted && !respAck;
            isAck    = accepted && respAck;
            doSend   = (held.size() - sentIdx > 0) && !isNack;
            mReplay  = 1'b0;
            if (isNack) begin
                mDiscard = (sentIdx + DEPTH - 1) % DEPTH;
                sentIdx  = 0;
                mReplay  = 1'b1;
                if (mCount < MAXCNT) mCount++;
            end else if (doSend) begin
                sentIdx++;
            end
            if (isAck) begin
                if (held.size() > 0) begin
                    void'(held.pop_front());
                    sentIdx--;
                end else begin
                    mSpur = 1'b1;
                end
            end
            if (doPush) held.push_back(dataIn);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every cycle, away from the rising edge, compare all outputs against the model.
    always @(negedge clk) begin
        if (cmpEn) begin
            automatic bit expValid = (held.size() - sentIdx > 0) || mReplay;
            checkOutput("valid", 32'(VALID_out), 32'(expValid));
            if (expValid) checkOutput("flit", 32'(FLIT_out), 32'(held[sentIdx]));
            checkOutput("replay_mark", 32'(FWDAUX1_out), 32'(mReplay));
            checkOutput("occupancy", 32'(occupancy), held.size());
            checkOutput("full", 32'(full), 32'(held.size() == DEPTH));
            checkOutput("almost_full", 32'(almost_full), 32'(held.size() >= DEPTH - 1));
            checkOutput("replay_count", 32'(replay_count), mCount);
            checkOutput("overflow_err", 32'(overflow_err), 32'(mOvf));
            checkOutput("spurious_err", 32'(spurious_ack_err), 32'(mSpur));
        end
    end

    task automatic applyStimulus(input bit w, input logic [FW-1:0] d, input bit rv, input bit ak);
        writeIn   = w;
        dataIn    = d;
        respValid = rv;
        respAck   = ak;
        aux3      = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (held.size() == 0) break;
            applyStimulus(1'b0, '0, (mDiscard > 0) || (sentIdx > 0), 1'b1);
        end
        checkOutput("drain_empty", 32'(occupancy), 32'd0);
    endtask

    initial begin
        int n, r;
        bit w, rv, ak;

        repeat (2) @(negedge clk);
        #1;
        cmpEn = 1'b1;
        checkOutput("rst_valid", 32'(VALID_out), 32'd0);
        checkOutput("rst_flit", 32'(FLIT_out), 32'd0);
        checkOutput("rst_occ", 32'(occupancy), 32'd0);
        rst = 1'b1;

        // Three back-to-back pushes with no responses.
        applyStimulus(1'b1, 16'hA0A0, 1'b0, 1'b1);
        checkOutput("dir_flitA", 32'(FLIT_out), 32'h0000A0A0);
        applyStimulus(1'b1, 16'hB0B0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'hC0C0, 1'b0, 1'b1);
        checkOutput("dir_flitC", 32'(FLIT_out), 32'h0000C0C0);
        checkOutput("dir_occ3", 32'(occupancy), 32'd3);
        checkOutput("dir_afull3", 32'(almost_full), 32'd1);
        checkOutput("dir_full3", 32'(full), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("dir_idle", 32'(VALID_out), 32'd0);
        drain();

        // Fill to full and keep writing once more.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0D01 + 16'(i), 1'b0, 1'b1);
        checkOutput("dir_full4", 32'(full), 32'd1);
        applyStimulus(1'b1, 16'h0DFF, 1'b0, 1'b1);
        checkOutput("dir_ovf", 32'(overflow_err), 32'd1);
        checkOutput("dir_occ4", 32'(occupancy), 32'd4);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("dir_ack4_occ", 32'(occupancy), 32'd0);
        checkOutput("dir_ack4_full", 32'(full), 32'd0);

        // Send four, NACK the oldest, and the three in-flight NACKs are swallowed.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h5100 + 16'(i), 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("nack_flit", 32'(FLIT_out), 32'h00005100);
        checkOutput("nack_mark", 32'(FWDAUX1_out), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("nack_count", 32'(replay_count), 32'd1);
        checkOutput("nack_resend", 32'(FLIT_out), 32'h00005103);
        drain();

        // Push and ACK in the same cycle at occupancy 2.
        applyStimulus(1'b1, 16'h7001, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h7002, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h7003, 1'b1, 1'b1);
        checkOutput("pushack_occ", 32'(occupancy), 32'd2);
        drain();

        // Stream 3*DEPTH flits through to exercise pointer wrap.
        n = 0;
        for (int i = 0; i < 80 && (n < 3 * DEPTH || held.size() > 0); i++) begin
            w = (n < 3 * DEPTH) && (held.size() < DEPTH);
            applyStimulus(w, 16'h9000 + 16'(n), sentIdx > 0, 1'b1);
            if (w) n++;
        end
        checkOutput("wrap_empty", 32'(occupancy), 32'd0);

        // ACK with nothing held.
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("spur_flag", 32'(spurious_ack_err), 32'd1);
        checkOutput("spur_occ", 32'(occupancy), 32'd0);

        // Asynchronous reset while a replay is in progress.
        applyStimulus(1'b1, 16'h6601, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h6602, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        #1 rst = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(VALID_out), 32'd0);
        checkOutput("arst_mark", 32'(FWDAUX1_out), 32'd0);
        checkOutput("arst_flit", 32'(FLIT_out), 32'd0);
        checkOutput("arst_count", 32'(replay_count), 32'd0);
        checkOutput("arst_ovf", 32'(overflow_err), 32'd0);
        checkOutput("arst_spur", 32'(spurious_ack_err), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b1, 16'h4242, 1'b0, 1'b1);
        checkOutput("post_rst_valid", 32'(VALID_out), 32'd1);
        checkOutput("post_rst_flit", 32'(FLIT_out), 32'h00004242);
        drain();

        // Five isolated NACKs saturate the 2-bit counter.
        applyStimulus(1'b1, 16'h3333, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
        end
        checkOutput("sat_count", 32'(replay_count), 32'd3);
        drain();

        // Random traffic with a well-behaved receiver.
        for (int c = 0; c < 1500; c++) begin
            w  = ($urandom_range(0, 3) != 0);
            r  = int'($urandom_range(0, 9));
            rv = 1'b0;
            ak = 1'b1;
            if (mDiscard > 0) begin
                rv = (r < 5);
                ak = ((r % 2) == 1);
            end else if (r == 0 && held.size() > 0) begin
                rv = 1'b1;
                ak = 1'b0;
            end else if (r < 6 && sentIdx > 0) begin
                rv = 1'b1;
            end else if (r == 9 && held.size() == 0) begin
                rv = 1'b1;
            end
            applyStimulus(w, 16'($urandom), rv, ak);
        end
        drain();

        cmpEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
